// File: rtl/gcd_pkg.sv
// -----------------------------------------------------------------------------
// gcd_pkg
// Shared definitions for the GCD host controller: default operand width and
// watchdog limit, the host FSM state type and the result record.
// -----------------------------------------------------------------------------
package gcd_pkg;

   localparam int unsigned GCD_DW      = 8;
   localparam int unsigned GCD_TIMEOUT = 255;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_WAIT,
      ST_HOLD
   } gcd_host_st_e;

   typedef struct packed {
      logic [GCD_DW-1:0] y;
      logic              err;
      logic              tmo;
   } gcd_res_t;

endpackage

// File: rtl/gcd_host_fifo.sv
// -----------------------------------------------------------------------------
// gcd_host_fifo
// Synchronous job FIFO holding {A,B} operand pairs (2*DW bits per entry).
// Ports:
//   CLK, RST_N         clock, asynchronous active-low reset (pointers only)
//   push_i / din_i     write request and data; ignored while full
//   pop_i / dout_o     read request and head-of-queue data; ignored while empty
//   full_o, empty_o    occupancy flags
// -----------------------------------------------------------------------------
module gcd_host_fifo #(
   parameter int unsigned DW    = 8,
   parameter int unsigned DEPTH = 4
) (
   input  logic            CLK,
   input  logic            RST_N,
   input  logic            push_i,
   input  logic [2*DW-1:0] din_i,
   input  logic            pop_i,
   output logic [2*DW-1:0] dout_o,
   output logic            full_o,
   output logic            empty_o
);

   localparam int unsigned AW = $clog2(DEPTH);

   // One extra pointer bit distinguishes full from empty when the indices match.
   logic [AW:0]     wr_q, wr_d, rd_q, rd_d;
   logic [2*DW-1:0] mem_q [DEPTH];
   logic            do_push, do_pop;

   assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
   assign empty_o = (wr_q == rd_q);
   assign do_push = push_i && !full_o;
   assign do_pop  = pop_i && !empty_o;
   assign dout_o  = mem_q[rd_q[AW-1:0]];

   always_comb begin
      wr_d = wr_q;
      rd_d = rd_q;
      if (do_push) wr_d = wr_q + (AW+1)'(1);
      if (do_pop)  rd_d = rd_q + (AW+1)'(1);
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         wr_q <= '0;
         rd_q <= '0;
      end else begin
         wr_q <= wr_d;
         rd_q <= rd_d;
      end
   end

   always_ff @(posedge CLK) begin
      if (do_push) mem_q[wr_q[AW-1:0]] <= din_i;
   end

endmodule

// File: rtl/gcd_host.sv
// -----------------------------------------------------------------------------
// gcd_host
// Initiator for a GCD engine: queues operand pairs from an upstream valid/ready
// stream, issues one job at a time (START pulse, A/B held until DONE), guards
// each job with a watchdog and returns result/error/timeout downstream.
// Ports:
//   CLK, RST_N                      clock, asynchronous active-low reset
//   IN_VALID/IN_READY/IN_A/IN_B     upstream job stream (IN_READY = FIFO not full)
//   G_START/G_A/G_B                 engine request (START one cycle wide)
//   G_DONE/G_Y/G_ERROR              engine response, sampled only in WAIT
//   OUT_VALID/OUT_READY             downstream result handshake
//   OUT_Y/OUT_ERR/OUT_TMO/OUT_LAT   result, engine error, watchdog abort, latency
// Build option: define GCD_HOST_LATENCY_EN to report per-job WAIT-cycle latency
// on OUT_LAT; otherwise OUT_LAT is tied to zero.
// -----------------------------------------------------------------------------
module gcd_host
   import gcd_pkg::*;
#(
   parameter int unsigned DW      = GCD_DW,
   parameter int unsigned DEPTH   = 4,
   parameter int unsigned TIMEOUT = GCD_TIMEOUT
) (
   input  logic          CLK,
   input  logic          RST_N,
   input  logic          IN_VALID,
   output logic          IN_READY,
   input  logic [DW-1:0] IN_A,
   input  logic [DW-1:0] IN_B,
   output logic          G_START,
   output logic [DW-1:0] G_A,
   output logic [DW-1:0] G_B,
   input  logic          G_DONE,
   input  logic [DW-1:0] G_Y,
   input  logic          G_ERROR,
   output logic          OUT_VALID,
   input  logic          OUT_READY,
   output logic [DW-1:0] OUT_Y,
   output logic          OUT_ERR,
   output logic          OUT_TMO,
   output logic [15:0]   OUT_LAT
);

   localparam int unsigned WDW = $clog2(TIMEOUT + 1);

   gcd_host_st_e    st_q, st_d;
   logic            fifo_full, fifo_empty, fifo_push, fifo_pop;
   logic [2*DW-1:0] fifo_dout;
   logic [DW-1:0]   ga_q, ga_d, gb_q, gb_d, y_q, y_d;
   logic            err_q, err_d, tmo_q, tmo_d;
   logic [WDW-1:0]  wd_q, wd_d;
   logic            done_ev, tmo_ev;

   assign fifo_push = IN_VALID && !fifo_full;
   assign IN_READY  = !fifo_full;

   gcd_host_fifo #(.DW(DW), .DEPTH(DEPTH)) u_fifo (
      .CLK     (CLK),
      .RST_N   (RST_N),
      .push_i  (fifo_push),
      .din_i   ({IN_A, IN_B}),
      .pop_i   (fifo_pop),
      .dout_o  (fifo_dout),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   // DONE is qualified by WAIT so a level left over from the previous job is
   // never taken as completion; DONE has priority over watchdog expiry.
   assign done_ev = (st_q == ST_WAIT) && G_DONE;
   assign tmo_ev  = (st_q == ST_WAIT) && !G_DONE && (wd_q == WDW'(TIMEOUT - 1));

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) st_q <= ST_IDLE;
      else        st_q <= st_d;
   end

   always_comb begin
      st_d = st_q;
      unique case (st_q)
         ST_IDLE:  if (!fifo_empty)        st_d = ST_ISSUE;
         ST_ISSUE:                         st_d = ST_WAIT;
         ST_WAIT:  if (done_ev || tmo_ev)  st_d = ST_HOLD;
         ST_HOLD:  if (OUT_READY)          st_d = ST_IDLE;
         default:                          st_d = ST_IDLE;
      endcase
   end

   always_comb begin
      G_START   = (st_q == ST_ISSUE);
      OUT_VALID = (st_q == ST_HOLD);
      fifo_pop  = (st_q == ST_IDLE) && !fifo_empty;
   end

   always_comb begin
      ga_d  = ga_q;
      gb_d  = gb_q;
      y_d   = y_q;
      err_d = err_q;
      tmo_d = tmo_q;
      wd_d  = wd_q;
      if (fifo_pop) {ga_d, gb_d} = fifo_dout;
      if (st_q == ST_ISSUE)     wd_d = '0;
      else if (st_q == ST_WAIT) wd_d = wd_q + WDW'(1);
      if (done_ev) begin
         y_d   = G_Y;
         err_d = G_ERROR;
         tmo_d = 1'b0;
      end else if (tmo_ev) begin
         y_d   = '0;
         err_d = 1'b0;
         tmo_d = 1'b1;
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         ga_q  <= '0;
         gb_q  <= '0;
         y_q   <= '0;
         err_q <= 1'b0;
         tmo_q <= 1'b0;
         wd_q  <= '0;
      end else begin
         ga_q  <= ga_d;
         gb_q  <= gb_d;
         y_q   <= y_d;
         err_q <= err_d;
         tmo_q <= tmo_d;
         wd_q  <= wd_d;
      end
   end

   assign G_A     = ga_q;
   assign G_B     = gb_q;
   assign OUT_Y   = y_q;
   assign OUT_ERR = err_q;
   assign OUT_TMO = tmo_q;

`ifdef GCD_HOST_LATENCY_EN
   // Loaded with 1 in ISSUE so the first WAIT cycle already reads 1.
   logic [15:0] lat_q, lat_d, lat_out_q, lat_out_d;

   always_comb begin
      lat_d     = lat_q;
      lat_out_d = lat_out_q;
      if (st_q == ST_ISSUE)                      lat_d = 16'd1;
      else if (st_q == ST_WAIT && lat_q != '1)   lat_d = lat_q + 16'd1;
      if (done_ev || tmo_ev)                     lat_out_d = lat_q;
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         lat_q     <= '0;
         lat_out_q <= '0;
      end else begin
         lat_q     <= lat_d;
         lat_out_q <= lat_out_d;
      end
   end

   assign OUT_LAT = lat_out_q;
`else
   assign OUT_LAT = '0;
`endif

endmodule

// File: tb/tb_gcd_host.sv
// -----------------------------------------------------------------------------
// tb_gcd_host
// Directed bench for gcd_host (TIMEOUT=20) with a behavioural GCD engine whose
// latency, never-done and sticky-DONE behaviour are selectable per test.
// -----------------------------------------------------------------------------
module tb_gcd_host;
   import gcd_pkg::*;

   localparam int unsigned TMO = 20;

   logic       CLK = 1'b0;
   logic       RST_N;
   logic       IN_VALID, IN_READY;
   logic [7:0] IN_A, IN_B;
   logic       G_START;
   logic [7:0] G_A, G_B;
   logic       G_DONE;
   logic [7:0] G_Y;
   logic       G_ERROR;
   logic       OUT_VALID, OUT_READY;
   logic [7:0] OUT_Y;
   logic       OUT_ERR, OUT_TMO;
   logic [15:0] OUT_LAT;

   gcd_host #(.DW(8), .DEPTH(4), .TIMEOUT(TMO)) dut (
      .CLK       (CLK),
      .RST_N     (RST_N),
      .IN_VALID  (IN_VALID),
      .IN_READY  (IN_READY),
      .IN_A      (IN_A),
      .IN_B      (IN_B),
      .G_START   (G_START),
      .G_A       (G_A),
      .G_B       (G_B),
      .G_DONE    (G_DONE),
      .G_Y       (G_Y),
      .G_ERROR   (G_ERROR),
      .OUT_VALID (OUT_VALID),
      .OUT_READY (OUT_READY),
      .OUT_Y     (OUT_Y),
      .OUT_ERR   (OUT_ERR),
      .OUT_TMO   (OUT_TMO),
      .OUT_LAT   (OUT_LAT)
   );

   always #5 CLK = ~CLK;

   int unsigned n_checks = 0;
   int unsigned n_errors = 0;
   int unsigned cyc = 0;

   always @(posedge CLK) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   // ---------------- behavioural GCD engine ----------------
   int unsigned m_lat    = 5;
   logic        m_never  = 1'b0;
   logic        m_sticky = 1'b0;
   int unsigned cnt;
   logic        hold_q;
   logic [7:0]  my;
   logic        merr;

   function automatic logic [7:0] gcd8(input logic [7:0] a_in, input logic [7:0] b_in);
      logic [7:0] a, b, t;
      a = a_in;
      b = b_in;
      if (a == 0 || b == 0) return 8'd0;
      while (b != 0) begin
         t = b;
         b = a % b;
         a = t;
      end
      return a;
   endfunction

   always @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         cnt    <= 0;
         hold_q <= 1'b0;
         my     <= '0;
         merr   <= 1'b0;
      end else if (G_START) begin
         cnt    <= m_never ? 0 : m_lat;
         hold_q <= 1'b0;
         my     <= gcd8(G_A, G_B);
         merr   <= (G_A == 0) || (G_B == 0);
      end else begin
         if (cnt > 0) cnt <= cnt - 1;
         if (cnt == 1 && m_sticky) hold_q <= 1'b1;
      end
   end

   assign G_DONE  = (cnt == 1) || (hold_q && m_sticky);
   assign G_Y     = my;
   assign G_ERROR = merr;

   // ---------------- START log ----------------
   int unsigned st_cyc[$];
   logic [7:0]  st_a[$];
   logic [7:0]  st_b[$];

   always @(negedge CLK) begin
      if (G_START) begin
         st_cyc.push_back(cyc);
         st_a.push_back(G_A);
         st_b.push_back(G_B);
      end
   end

   task automatic clear_log();
      st_cyc.delete();
      st_a.delete();
      st_b.delete();
   endtask

   // Called at a negedge; returns the cycle index after the accepting edge.
   task automatic push(input logic [7:0] a, input logic [7:0] b, output int unsigned acc);
      int unsigned n = 0;
      IN_A = a;
      IN_B = b;
      IN_VALID = 1'b1;
      while (!IN_READY && n < 200) begin
         @(negedge CLK);
         n++;
      end
      check("push_ready", IN_READY, 1);
      @(negedge CLK);
      acc = cyc;
      IN_VALID = 1'b0;
   endtask

   task automatic get_result(input string tag, output logic [7:0] y, output logic err,
                             output logic tmo, output logic [15:0] lat, output int unsigned vc);
      int unsigned n = 0;
      while (!OUT_VALID && n < 200) begin
         @(negedge CLK);
         n++;
      end
      check({tag, "_valid"}, OUT_VALID, 1);
      y   = OUT_Y;
      err = OUT_ERR;
      tmo = OUT_TMO;
      lat = OUT_LAT;
      vc  = cyc;
      OUT_READY = 1'b1;
      @(negedge CLK);
      OUT_READY = 1'b0;
   endtask

   logic [7:0]  ry;
   logic        rerr, rtmo;
   logic [15:0] rlat;
   int unsigned vc, acc, n;
   gcd_res_t    exp_r;

`ifdef GCD_HOST_LATENCY_EN
   localparam bit LAT_ON = 1'b1;
`else
   localparam bit LAT_ON = 1'b0;
`endif

   initial begin
      RST_N = 1'b0;
      IN_VALID = 1'b0;
      IN_A = '0;
      IN_B = '0;
      OUT_READY = 1'b0;

      // Reset state, observed before the first clock edge.
      #2;
      check("rst_in_ready", IN_READY, 1);
      check("rst_g_start", G_START, 0);
      check("rst_g_a", G_A, 0);
      check("rst_g_b", G_B, 0);
      check("rst_out_valid", OUT_VALID, 0);
      check("rst_out_y", OUT_Y, 0);
      check("rst_out_flags", {OUT_ERR, OUT_TMO}, 0);
      check("rst_out_lat", OUT_LAT, 0);
      repeat (2) @(negedge CLK);
      RST_N = 1'b1;
      @(negedge CLK);

      // T1: single job, latency 5.
      clear_log();
      push(8'd21, 8'd6, acc);
      get_result("t1", ry, rerr, rtmo, rlat, vc);
      check("t1_nstart", st_cyc.size(), 1);
      check("t1_ga", st_a[0], 21);
      check("t1_gb", st_b[0], 6);
      check("t1_issue_delay", st_cyc[0] - acc, 1);
      check("t1_valid_delay", vc - st_cyc[0], 6);
      exp_r = '{y: 8'd3, err: 1'b0, tmo: 1'b0};
      check("t1_res", {ry, rerr, rtmo}, exp_r);
      check("t1_lat", rlat, LAT_ON ? 5 : 0);
      check("t1_valid_drop", OUT_VALID, 0);

      // T2: back-to-back jobs, in-order results.
      clear_log();
      push(8'd75, 8'd60, acc);
      push(8'd21, 8'd6, acc);
      push(8'd0, 8'd5, acc);
      get_result("t2a", ry, rerr, rtmo, rlat, vc);
      check("t2a_res", {ry, rerr, rtmo}, {8'd15, 1'b0, 1'b0});
      get_result("t2b", ry, rerr, rtmo, rlat, vc);
      check("t2b_res", {ry, rerr, rtmo}, {8'd3, 1'b0, 1'b0});
      get_result("t2c", ry, rerr, rtmo, rlat, vc);
      check("t2c_res", {ry, rerr, rtmo}, {8'd0, 1'b1, 1'b0});
      check("t2_nstart", st_cyc.size(), 3);
      check("t2_gap1", (st_cyc[1] - st_cyc[0]) >= 8, 1);
      check("t2_gap2", (st_cyc[2] - st_cyc[1]) >= 8, 1);

      // T3: downstream stall fills the FIFO.
      push(8'd21, 8'd6, acc);
      n = 0;
      while (!OUT_VALID && n < 100) begin
         @(negedge CLK);
         n++;
      end
      check("t3_hold", OUT_VALID, 1);
      push(8'd75, 8'd60, acc);
      push(8'd12, 8'd18, acc);
      push(8'd7, 8'd5, acc);
      push(8'd100, 8'd75, acc);
      check("t3_full", IN_READY, 0);
      IN_A = 8'd48;
      IN_B = 8'd36;
      IN_VALID = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge CLK);
         check("t3_stall_ready", IN_READY, 0);
         check("t3_stall_valid", OUT_VALID, 1);
         check("t3_stall_out", {OUT_Y, OUT_ERR, OUT_TMO}, {8'd3, 1'b0, 1'b0});
      end
      OUT_READY = 1'b1;
      @(negedge CLK);
      OUT_READY = 1'b0;
      check("t3_nobypass", IN_READY, 0);
      check("t3_valid_off", OUT_VALID, 0);
      @(negedge CLK);
      check("t3_after_pop", IN_READY, 1);
      @(negedge CLK);
      IN_VALID = 1'b0;
      check("t3_refull", IN_READY, 0);
      get_result("t3a", ry, rerr, rtmo, rlat, vc);
      check("t3a_y", ry, 15);
      get_result("t3b", ry, rerr, rtmo, rlat, vc);
      check("t3b_y", ry, 6);
      get_result("t3c", ry, rerr, rtmo, rlat, vc);
      check("t3c_y", ry, 1);
      get_result("t3d", ry, rerr, rtmo, rlat, vc);
      check("t3d_y", ry, 25);
      get_result("t3e", ry, rerr, rtmo, rlat, vc);
      check("t3e_y", ry, 12);

      // T4: watchdog abort, then a normal job.
      clear_log();
      m_never = 1'b1;
      push(8'd9, 8'd6, acc);
      get_result("t4", ry, rerr, rtmo, rlat, vc);
      check("t4_res", {ry, rerr, rtmo}, {8'd0, 1'b0, 1'b1});
      // ISSUE cycle, then TMO cycles of WAIT, then HOLD.
      check("t4_tmo_delay", vc - st_cyc[0], TMO + 1);
      check("t4_lat", rlat, LAT_ON ? TMO : 0);
      m_never = 1'b0;
      push(8'd21, 8'd6, acc);
      get_result("t4b", ry, rerr, rtmo, rlat, vc);
      check("t4b_res", {ry, rerr, rtmo}, {8'd3, 1'b0, 1'b0});

      // T5: asynchronous reset mid-WAIT with two jobs queued.
      clear_log();
      m_lat = 10;
      push(8'd75, 8'd60, acc);
      push(8'd21, 8'd6, acc);
      push(8'd12, 8'd18, acc);
      n = 0;
      while (st_cyc.size() == 0 && n < 50) begin
         @(negedge CLK);
         n++;
      end
      repeat (3) @(negedge CLK);
      check("t5_pre_ga", G_A, 75);
      #2 RST_N = 1'b0;
      #1;
      check("t5_ga", G_A, 0);
      check("t5_gb", G_B, 0);
      check("t5_start", G_START, 0);
      check("t5_valid", OUT_VALID, 0);
      check("t5_out", {OUT_Y, OUT_ERR, OUT_TMO}, 0);
      check("t5_lat", OUT_LAT, 0);
      check("t5_ready", IN_READY, 1);
      repeat (2) @(negedge CLK);
      clear_log();
      RST_N = 1'b1;
      repeat (15) @(negedge CLK);
      check("t5_no_start", st_cyc.size(), 0);
      m_lat = 5;
      push(8'd21, 8'd6, acc);
      get_result("t5b", ry, rerr, rtmo, rlat, vc);
      check("t5b_y", ry, 3);
      check("t5b_nstart", st_cyc.size(), 1);

      // T6: DONE left high from the previous job through ISSUE.
      clear_log();
      m_sticky = 1'b1;
      push(8'd75, 8'd60, acc);
      push(8'd21, 8'd6, acc);
      get_result("t6a", ry, rerr, rtmo, rlat, vc);
      check("t6a_y", ry, 15);
      get_result("t6b", ry, rerr, rtmo, rlat, vc);
      check("t6b_y", ry, 3);
      check("t6b_delay", vc - st_cyc[1], 6);
      check("t6_gap", st_cyc[1] - st_cyc[0], 8);
      m_sticky = 1'b0;

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout got=%0d exp=%0d", cyc, 0);
      $fatal(1, "timeout");
   end

endmodule
